// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the two-client SDRAM arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int CALL_READ  = 0;
    localparam int CALL_WRITE = 1;
    localparam int CALL_CREAD = 2;
    localparam int CALL_W     = 3;

    // A malformed multi-bit call is reduced to its highest set bit.
    function automatic logic [CALL_W-1:0] reduceCall(input logic [CALL_W-1:0] call);
        logic [CALL_W-1:0] r;
        r = '0;
        if (call[CALL_CREAD])      r[CALL_CREAD] = 1'b1;
        else if (call[CALL_WRITE]) r[CALL_WRITE] = 1'b1;
        else if (call[CALL_READ])  r[CALL_READ]  = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner selection: client 0 has priority unless client 1 has waited MAX_RUN grants.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int MAX_RUN = 4
) (
    input  logic [CALL_W-1:0] call0,
    input  logic [CALL_W-1:0] call1,
    input  logic [3:0]        run,
    output logic              winner,
    output logic [CALL_W-1:0] callBits
);

    always_comb begin
        winner = 1'b0;
        if (call0 == '0)
            winner = 1'b1;
        else if (call1 != '0 && run == 4'(MAX_RUN))
            winner = 1'b1;
        callBits = reduceCall(winner ? call1 : call0);
    end

endmodule

// File: rtl/sdram_arbmod.sv
// Two-client arbiter sharing one sdram_basemod call/done port.
// Optional busy watchdog enabled by defining SDRAM_ARB_WDOG_EN.
module sdram_arbmod
    import sdram_arb_pkg::*;
#(
    parameter int MAX_RUN     = 4,
    parameter int WDOG_CYCLES = 1024,
    parameter int AW          = 24,
    parameter int DW          = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [CALL_W-1:0] iCall0,
    input  logic [CALL_W-1:0] iCall1,
    output logic [CALL_W-1:0] oDone0,
    output logic [CALL_W-1:0] oDone1,
    input  logic [AW-1:0]     iAddr0,
    input  logic [AW-1:0]     iAddr1,
    input  logic [AW-1:0]     iAddrPage0,
    input  logic [AW-1:0]     iAddrPage1,
    input  logic [DW-1:0]     iData0,
    input  logic [DW-1:0]     iData1,
    output logic              oEn0,
    output logic              oEn1,
    output logic [DW-1:0]     oData0,
    output logic [DW-1:0]     oData1,
    output logic [CALL_W-1:0] oCall,
    input  logic [CALL_W-1:0] iDone,
    input  logic              iEn,
    input  logic [DW-1:0]     iData,
    output logic [AW-1:0]     oAddr,
    output logic [AW-1:0]     oAddrPage,
    output logic [DW-1:0]     oData,
    output logic              oErr
);

    state_t            state, nextState;
    logic              grant;
    logic [CALL_W-1:0] callLat;
    logic [CALL_W-1:0] doneR;
    logic [3:0]        run;
    logic              winner;
    logic [CALL_W-1:0] pickCall;
    logic              anyCall;
    logic              wdogTrip;
    logic              doneHit;

    sdram_arb_pick #(.MAX_RUN(MAX_RUN)) uPick (
        .call0    (iCall0),
        .call1    (iCall1),
        .run      (run),
        .winner   (winner),
        .callBits (pickCall)
    );

    assign anyCall = (iCall0 != '0) || (iCall1 != '0);

`ifdef SDRAM_ARB_WDOG_EN
    logic [15:0] wdogCnt;
    logic        errR;

    assign wdogTrip = (state == BUSY) && (wdogCnt == 16'(WDOG_CYCLES - 1));

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wdogCnt <= '0;
            errR    <= 1'b0;
        end else begin
            wdogCnt <= (state == BUSY) ? wdogCnt + 16'd1 : 16'd0;
            if (wdogTrip && iDone == '0)
                errR <= 1'b1;
        end
    end

    assign oErr = errR;
`else
    assign wdogTrip = 1'b0;
    assign oErr     = 1'b0;
`endif

    // A timeout completes the transaction like a real done so the client never hangs.
    assign doneHit = (iDone != '0) || wdogTrip;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyCall) nextState = BUSY;
            BUSY:    if (doneHit) nextState = RELEASE;
            RELEASE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            grant     <= 1'b0;
            callLat   <= '0;
            doneR     <= '0;
            run       <= '0;
            oAddr     <= '0;
            oAddrPage <= '0;
            oData     <= '0;
        end else begin
            doneR <= '0;
            case (state)
                IDLE: begin
                    if (iCall1 == '0)
                        run <= '0;
                    if (anyCall) begin
                        grant     <= winner;
                        callLat   <= pickCall;
                        oAddr     <= winner ? iAddr1     : iAddr0;
                        oAddrPage <= winner ? iAddrPage1 : iAddrPage0;
                        oData     <= winner ? iData1     : iData0;
                        if (winner)
                            run <= '0;
                        else if (iCall1 != '0 && run != 4'(MAX_RUN))
                            run <= run + 4'd1;
                    end
                end
                BUSY: if (doneHit) doneR <= callLat;
                default: ;
            endcase
        end
    end

    assign oCall  = (state == BUSY) ? callLat : '0;
    assign oDone0 = grant ? '0 : doneR;
    assign oDone1 = grant ? doneR : '0;
    assign oEn0   = (state == BUSY) && iEn && !grant;
    assign oEn1   = (state == BUSY) && iEn && grant;
    assign oData0 = iData;
    assign oData1 = iData;

endmodule

// File: tb/tb_sdram_arbmod.sv
// Directed bench for sdram_arbmod: a hand-driven stub plays sdram_basemod.
module tb_sdram_arbmod;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          CLOCK, RESET;
    logic [2:0]    iCall0, iCall1, oDone0, oDone1, oCall, iDone;
    logic [AW-1:0] iAddr0, iAddr1, iAddrPage0, iAddrPage1, oAddr, oAddrPage;
    logic [DW-1:0] iData0, iData1, oData0, oData1, iData, oData;
    logic          oEn0, oEn1, iEn, oErr;

    int checks = 0;
    int errors = 0;

    sdram_arbmod #(.MAX_RUN(4), .WDOG_CYCLES(16), .AW(AW), .DW(DW)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .iCall0(iCall0), .iCall1(iCall1), .oDone0(oDone0), .oDone1(oDone1),
        .iAddr0(iAddr0), .iAddr1(iAddr1), .iAddrPage0(iAddrPage0), .iAddrPage1(iAddrPage1),
        .iData0(iData0), .iData1(iData1), .oEn0(oEn0), .oEn1(oEn1),
        .oData0(oData0), .oData1(oData1), .oCall(oCall), .iDone(iDone),
        .iEn(iEn), .iData(iData), .oAddr(oAddr), .oAddrPage(oAddrPage),
        .oData(oData), .oErr(oErr)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic waitCall(input string nm);
        int n = 0;
        while (oCall == 3'b000 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (oCall == 3'b000) begin
            errors++;
            $display("FAIL %s: oCall stayed %b, required nonzero within 10 cycles", nm, oCall);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({oCall, oDone0, oDone1, oEn0, oEn1, oErr} !== 12'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 0", {oCall, oDone0, oDone1, oEn0, oEn1, oErr});
        end
        checks++;
        if ({oAddr, oAddrPage, oData} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h, want 0", oAddr, oAddrPage, oData);
        end
        tick();
        RESET = 1'b0;
        iDone = 3'b010;
        tick();
        checks++;
        if ({oDone0, oDone1, oCall} !== 9'd0) begin
            errors++;
            $display("FAIL idle_done_ignored: got %b, want 0", {oDone0, oDone1, oCall});
        end
        iDone = 3'b000;
        tick();
    endtask

    task automatic test_write1();
        iCall1 = 3'b010; iAddr1 = 24'h000123; iData1 = 16'hBEEF;
        #1;
        checks++;
        if (oCall !== 3'b000) begin errors++; $display("FAIL wr_nocall_idle: got %b, want 000", oCall); end
        tick();
        checks++;
        if (oCall !== 3'b010 || oAddr !== 24'h000123 || oData !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_forward: got %b %h %h, want 010 000123 beef", oCall, oAddr, oData);
        end
        repeat (3) tick();
        checks++;
        if (oCall !== 3'b010) begin errors++; $display("FAIL wr_hold: got %b, want 010", oCall); end
        tick();
        iDone = 3'b010;
        tick();
        checks++;
        if (oDone1 !== 3'b010 || oDone0 !== 3'b000 || oCall !== 3'b000) begin
            errors++;
            $display("FAIL wr_done: got d1=%b d0=%b call=%b, want 010 000 000", oDone1, oDone0, oCall);
        end
        iDone = 3'b000; iCall1 = 3'b000;
        tick();
        checks++;
        if (oDone1 !== 3'b000) begin errors++; $display("FAIL wr_done_once: got %b, want 000", oDone1); end
        tick();
    endtask

    task automatic test_simultaneous();
        iCall0 = 3'b001; iAddr0 = 24'h0000A0;
        iCall1 = 3'b001; iAddr1 = 24'h0000B1;
        tick();
        checks++;
        if (oCall !== 3'b001 || oAddr !== 24'h0000A0) begin
            errors++;
            $display("FAIL sim_first: got %b %h, want 001 0000a0", oCall, oAddr);
        end
        iDone = 3'b001;
        tick();
        checks++;
        if (oDone0 !== 3'b001 || oDone1 !== 3'b000) begin
            errors++;
            $display("FAIL sim_done0: got d0=%b d1=%b, want 001 000", oDone0, oDone1);
        end
        iDone = 3'b000; iCall0 = 3'b000;
        tick();
        checks++;
        if (oCall !== 3'b000) begin errors++; $display("FAIL sim_gap: got %b, want 000", oCall); end
        tick();
        checks++;
        if (oCall !== 3'b001 || oAddr !== 24'h0000B1) begin
            errors++;
            $display("FAIL sim_second_d3: got %b %h, want 001 0000b1", oCall, oAddr);
        end
        iDone = 3'b001;
        tick();
        checks++;
        if (oDone1 !== 3'b001 || oDone0 !== 3'b000) begin
            errors++;
            $display("FAIL sim_done1: got d1=%b d0=%b, want 001 000", oDone1, oDone0);
        end
        iDone = 3'b000; iCall1 = 3'b000;
        repeat (2) tick();
    endtask

    task automatic test_starvation();
        logic [11:0] expOrder;
        logic        g;
        expOrder = 12'b0010_0001_0000;
        iCall0 = 3'b001; iAddr0 = 24'h000C00;
        iCall1 = 3'b001; iAddr1 = 24'h000C11;
        for (int i = 0; i < 12; i++) begin
            waitCall("order_wait");
            g = (oAddr == 24'h000C11);
            checks++;
            if (g !== expOrder[i]) begin
                errors++;
                $display("FAIL order_%0d: granted client %0d, want %0d", i, g, expOrder[i]);
            end
            iDone = 3'b001;
            tick();
            iDone = 3'b000;
            if (i == 11) begin iCall0 = 3'b000; iCall1 = 3'b000; end
        end
        repeat (2) tick();
    endtask

    task automatic test_cread();
        logic [DW-1:0] expD;
        iCall0 = 3'b100; iAddrPage0 = 24'hABCDE0;
        iCall1 = 3'b001;
        tick();
        checks++;
        if (oCall !== 3'b100 || oAddrPage !== 24'hABCDE0) begin
            errors++;
            $display("FAIL cr_forward: got %b %h, want 100 abcde0", oCall, oAddrPage);
        end
        for (int i = 0; i < 8; i++) begin
            expD = 16'(16'h1111 + i);
            iEn = 1'b1; iData = expD;
            #1;
            checks++;
            if (oEn0 !== 1'b1 || oEn1 !== 1'b0 || oData0 !== expD) begin
                errors++;
                $display("FAIL cr_beat_%0d: got en0=%b en1=%b d=%h, want 1 0 %h", i, oEn0, oEn1, oData0, expD);
            end
            tick();
            iEn = 1'b0;
            #1;
            checks++;
            if (oEn0 !== 1'b0 || oEn1 !== 1'b0) begin
                errors++;
                $display("FAIL cr_gap_%0d: got en0=%b en1=%b, want 0 0", i, oEn0, oEn1);
            end
            tick();
        end
        iDone = 3'b100;
        tick();
        checks++;
        if (oDone0 !== 3'b100 || oDone1 !== 3'b000) begin
            errors++;
            $display("FAIL cr_done: got d0=%b d1=%b, want 100 000", oDone0, oDone1);
        end
        iDone = 3'b000; iCall0 = 3'b000; iCall1 = 3'b000;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        iCall1 = 3'b001; iAddr1 = 24'h000042;
        tick();
        checks++;
        if (oCall !== 3'b001) begin errors++; $display("FAIL rst_busy: got %b, want 001", oCall); end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (oCall !== 3'b000 || oDone1 !== 3'b000 || oAddr !== '0) begin
            errors++;
            $display("FAIL rst_async: got %b %b %h, want 000 000 0", oCall, oDone1, oAddr);
        end
        tick();
        checks++;
        if (oCall !== 3'b000 || oDone1 !== 3'b000) begin
            errors++;
            $display("FAIL rst_held: got %b %b, want 000 000", oCall, oDone1);
        end
        RESET = 1'b0;
        tick();
        checks++;
        if (oCall !== 3'b001 || oAddr !== 24'h000042) begin
            errors++;
            $display("FAIL rst_resume: got %b %h, want 001 000042", oCall, oAddr);
        end
        iDone = 3'b001;
        tick();
        checks++;
        if (oDone1 !== 3'b001) begin errors++; $display("FAIL rst_done: got %b, want 001", oDone1); end
        iDone = 3'b000; iCall1 = 3'b000;
        repeat (2) tick();
    endtask

    task automatic test_watchdog();
        iCall0 = 3'b010; iAddr0 = 24'h000777;
        tick();
`ifdef SDRAM_ARB_WDOG_EN
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (oCall !== 3'b010) begin errors++; $display("FAIL wd_hold_%0d: got %b, want 010", i, oCall); end
            tick();
        end
        checks++;
        if (oCall !== 3'b000 || oDone0 !== 3'b010 || oErr !== 1'b1) begin
            errors++;
            $display("FAIL wd_trip: got %b %b %b, want 000 010 1", oCall, oDone0, oErr);
        end
        iCall0 = 3'b000;
        repeat (3) tick();
        checks++;
        if (oErr !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b, want 1", oErr); end
`else
        for (int i = 1; i <= 40; i++) begin
            checks++;
            if (oCall !== 3'b010 || oErr !== 1'b0) begin
                errors++;
                $display("FAIL nowd_hold_%0d: got %b %b, want 010 0", i, oCall, oErr);
            end
            tick();
        end
        iCall0 = 3'b000;
`endif
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if (oErr !== 1'b0 || oCall !== 3'b000) begin
            errors++;
            $display("FAIL wd_reset_clear: got %b %b, want 0 000", oErr, oCall);
        end
    endtask

    initial begin
        RESET = 1'b1;
        iCall0 = '0; iCall1 = '0; iDone = '0; iEn = 1'b0; iData = '0;
        iAddr0 = '0; iAddr1 = '0; iAddrPage0 = '0; iAddrPage1 = '0;
        iData0 = '0; iData1 = '0;
        #12;
        test_reset();
        test_write1();
        test_simultaneous();
        test_starvation();
        test_cread();
        test_reset_mid();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
